// File: rtl/board_step_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | board_step_ctrl_if                                                         |
// | Switches, buttons, debug bus and LED/CPU-enable outputs of the controller. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface board_step_ctrl_if #(
    parameter int NUM_CH = 8,
    parameter int DBG_W  = 32,
    parameter int LED_W  = 8,
    parameter int CNT_W  = 16
);
    localparam int C_CH_W  = $clog2(NUM_CH);
    localparam int C_PAGES = DBG_W / LED_W;
    localparam int C_PG_W  = (C_PAGES > 1) ? $clog2(C_PAGES) : 1;

    logic [1:0]              mode;
    logic                    step_btn;
    logic                    page_btn;
    logic [C_CH_W-1:0]       ch_sel;
    logic [NUM_CH*DBG_W-1:0] dbg_bus;
    logic                    cpu_ce;
    logic [LED_W-1:0]        led;
    logic [C_PG_W-1:0]       page;
    logic [CNT_W-1:0]        step_count;

    modport master (
        output mode, step_btn, page_btn, ch_sel, dbg_bus,
        input  cpu_ce, led, page, step_count
    );

    modport slave (
        input  mode, step_btn, page_btn, ch_sel, dbg_bus,
        output cpu_ce, led, page, step_count
    );
endinterface
`default_nettype wire

// File: rtl/board_step_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | board_step_ctrl                                                            |
// | Run/step CPU clock-enable generator and paged debug LED viewer.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module board_step_ctrl #(
    parameter int DIV_WIDTH  = 24,
    parameter int DEB_CYCLES = 500000,
    parameter int NUM_CH     = 8,
    parameter int DBG_W      = 32,
    parameter int LED_W      = 8,
    parameter int CNT_W      = 16
) (
    input  wire logic        mainClk,
    input  wire logic        reset,
    board_step_ctrl_if.slave bus
);
    localparam int C_CH_W  = $clog2(NUM_CH);
    localparam int C_PAGES = DBG_W / LED_W;
    localparam int C_PG_W  = (C_PAGES > 1) ? $clog2(C_PAGES) : 1;
    localparam int C_DEB_W = $clog2(DEB_CYCLES);
    localparam logic [C_DEB_W-1:0] C_DEB_LAST = C_DEB_W'(DEB_CYCLES - 1);
    localparam logic [C_PG_W-1:0]  C_PG_LAST  = C_PG_W'(C_PAGES - 1);
    localparam logic [C_CH_W:0]    C_NUM_CH   = (C_CH_W + 1)'(NUM_CH);

    // Index 0 is the step button, index 1 the page button.
    logic [1:0] w_btn;
    logic [1:0] w_press;

    assign w_btn = {bus.page_btn, bus.step_btn};

    for (genvar b = 0; b < 2; b++) begin : g_btn
        logic [1:0]         sync_q, sync_d;
        logic [C_DEB_W-1:0] cnt_q, cnt_d;
        logic               lvl_q, lvl_d;
        logic               lvl_prev_q, lvl_prev_d;

        always_comb begin
            sync_d     = {sync_q[0], w_btn[b]};
            lvl_prev_d = lvl_q;
            lvl_d      = lvl_q;
            cnt_d      = '0;
            if (sync_q[1] != lvl_q) begin
                if (cnt_q == C_DEB_LAST) begin
                    lvl_d = ~lvl_q;
                end else begin
                    cnt_d = cnt_q + C_DEB_W'(1);
                end
            end
        end

        always_ff @(posedge mainClk or negedge reset) begin
            if (!reset) begin
                sync_q     <= '0;
                cnt_q      <= '0;
                lvl_q      <= 1'b0;
                lvl_prev_q <= 1'b0;
            end else begin
                sync_q     <= sync_d;
                cnt_q      <= cnt_d;
                lvl_q      <= lvl_d;
                lvl_prev_q <= lvl_prev_d;
            end
        end

        assign w_press[b] = lvl_q & ~lvl_prev_q;
    end

    logic [LED_W-1:0] w_slice [NUM_CH][C_PAGES];

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        for (genvar p = 0; p < C_PAGES; p++) begin : g_pg
            assign w_slice[k][p] = bus.dbg_bus[k*DBG_W + p*LED_W +: LED_W];
        end
    end

    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic                 cpu_ce_q, cpu_ce_d;
    logic [CNT_W-1:0]     step_count_q, step_count_d;
    logic [C_PG_W-1:0]    page_q, page_d;
    logic [C_CH_W-1:0]    ch_prev_q, ch_prev_d;
    logic [LED_W-1:0]     led_q, led_d;
    logic [C_CH_W-1:0]    w_ch_eff;

    always_comb begin
        div_d        = (bus.mode == 2'b01) ? div_q + DIV_WIDTH'(1) : '0;
        // The divider term is not gated by mode so a pulse pending at all-ones survives a mode change.
        cpu_ce_d     = ~cpu_ce_q & ((div_q == '1) | ((bus.mode == 2'b10) & w_press[0]));
        step_count_d = step_count_q + CNT_W'(cpu_ce_d);
        ch_prev_d    = bus.ch_sel;
        page_d       = page_q;
        if (bus.ch_sel != ch_prev_q) begin
            page_d = '0;
        end else if (w_press[1]) begin
            page_d = (page_q == C_PG_LAST) ? '0 : page_q + C_PG_W'(1);
        end
        w_ch_eff = ({1'b0, bus.ch_sel} < C_NUM_CH) ? bus.ch_sel : '0;
        led_d    = w_slice[w_ch_eff][page_q];
    end

    always_ff @(posedge mainClk or negedge reset) begin
        if (!reset) begin
            div_q        <= '0;
            cpu_ce_q     <= 1'b0;
            step_count_q <= '0;
            page_q       <= '0;
            ch_prev_q    <= '0;
            led_q        <= '0;
        end else begin
            div_q        <= div_d;
            cpu_ce_q     <= cpu_ce_d;
            step_count_q <= step_count_d;
            page_q       <= page_d;
            ch_prev_q    <= ch_prev_d;
            led_q        <= led_d;
        end
    end

    assign bus.cpu_ce     = cpu_ce_q;
    assign bus.step_count = step_count_q;
    assign bus.page       = page_q;
    assign bus.led        = led_q;
endmodule
`default_nettype wire

// File: tb/tb_board_step_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_board_step_ctrl                                                         |
// | Directed and randomized checks of board_step_ctrl against a timing model.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_board_step_ctrl;
    localparam int DIV_WIDTH  = 3;
    localparam int DEB_CYCLES = 4;
    localparam int NUM_CH     = 4;
    localparam int DBG_W      = 16;
    localparam int LED_W      = 8;
    localparam int CNT_W      = 4;
    localparam int PERIOD     = 1 << DIV_WIDTH;
    localparam int CNT_MOD    = 1 << CNT_W;
    localparam int PAGES      = DBG_W / LED_W;
    // Rising edge of a held button to cpu_ce: 2 sync + DEB_CYCLES debounce + 1 register.
    localparam int PRESS_LAT  = 2 + DEB_CYCLES + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    int         count_m = 0;
    int         page_m  = 0;
    logic [1:0] ch_m    = 2'd0;

    board_step_ctrl_if #(.NUM_CH(NUM_CH), .DBG_W(DBG_W), .LED_W(LED_W), .CNT_W(CNT_W)) bif ();
    board_step_ctrl_if #(.NUM_CH(3), .DBG_W(DBG_W), .LED_W(LED_W), .CNT_W(CNT_W)) bif3 ();

    board_step_ctrl #(
        .DIV_WIDTH(DIV_WIDTH), .DEB_CYCLES(DEB_CYCLES), .NUM_CH(NUM_CH),
        .DBG_W(DBG_W), .LED_W(LED_W), .CNT_W(CNT_W)
    ) dut (
        .mainClk (clk),
        .reset   (rst_n),
        .bus     (bif.slave)
    );

    board_step_ctrl #(
        .DIV_WIDTH(DIV_WIDTH), .DEB_CYCLES(DEB_CYCLES), .NUM_CH(3),
        .DBG_W(DBG_W), .LED_W(LED_W), .CNT_W(CNT_W)
    ) dut3 (
        .mainClk (clk),
        .reset   (rst_n),
        .bus     (bif3.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] led_ref(input logic [63:0] dbg, input int ch, input int pg);
        logic [63:0] t;
        t = dbg >> (ch * DBG_W + pg * LED_W);
        return t[7:0];
    endfunction

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            tick();
            chk("cpu_ce_idle", bif.cpu_ce, 1'b0);
        end
    endtask

    // Free-run for n cycles, then one cycle in halt: pulses fall on every PERIOD-th cycle.
    task automatic free_run(input int n);
        logic exp_ce;
        bif.mode = 2'b01;
        for (int k = 1; k <= n + 1; k++) begin
            if (k == n + 1) bif.mode = 2'b00;
            tick();
            exp_ce = (k % PERIOD == 0);
            if (exp_ce) count_m = (count_m + 1) % CNT_MOD;
            chk("cpu_ce_free", bif.cpu_ce, exp_ce);
            chk("step_count_free", bif.step_count, count_m);
        end
    endtask

    // Button held for h cycles then released; optional ch_sel change before cycle chg_at.
    task automatic episode(input int btn, input int h, input int len, input int chg_at, input logic [1:0] new_ch);
        logic acc, fire;
        acc  = (h >= DEB_CYCLES);
        fire = acc && (btn == 0) && (bif.mode == 2'b10);
        for (int k = 1; k <= len; k++) begin
            if (btn == 0) bif.step_btn = (k <= h);
            else          bif.page_btn = (k <= h);
            if (chg_at == k) bif.ch_sel = new_ch;
            tick();
            chk("cpu_ce_press", bif.cpu_ce, fire && (k == PRESS_LAT));
        end
        if (fire) count_m = (count_m + 1) % CNT_MOD;
        if (chg_at > 0 && new_ch != ch_m) page_m = 0;
        else if (acc && btn == 1) page_m = (page_m + 1) % PAGES;
        if (chg_at > 0) ch_m = new_ch;
        chk("step_count", bif.step_count, count_m);
        chk("page", bif.page, page_m);
        chk("led", bif.led, led_ref(bif.dbg_bus, ch_m, page_m));
    endtask

    initial begin
        logic [31:0] r;
        int          h;
        int          chg;
        int          act;
        logic [1:0]  nch;

        bif.mode = 2'b00;  bif.step_btn = 1'b0;  bif.page_btn = 1'b0;
        bif.ch_sel = 2'd0; bif.dbg_bus = {$urandom(), $urandom()};
        r = $urandom();
        bif3.mode = 2'b00; bif3.step_btn = 1'b0; bif3.page_btn = 1'b0;
        bif3.ch_sel = 2'd0; bif3.dbg_bus = {r, 16'h00FF};

        #2 rst_n = 1'b0;
        #1;
        chk("rst_cpu_ce", bif.cpu_ce, 1'b0);
        chk("rst_led", bif.led, 8'h00);
        chk("rst_page", bif.page, 1'b0);
        chk("rst_step_count", bif.step_count, 4'h0);
        tick();
        chk("rst_hold_cpu_ce", bif.cpu_ce, 1'b0);
        rst_n = 1'b1;
        tick();

        // Free-run leaving exactly at all-ones, then leaving mid-count.
        free_run(39);
        chk("step_count_40", bif.step_count, 4'd5);
        free_run(11);
        idle(10);
        chk("div_halt", dut.div_q, 3'd0);

        // Debounced step: glitch, then a long hold with release.
        bif.mode = 2'b10;
        episode(0, 2, 16, 0, ch_m);
        episode(0, 20, 34, 0, ch_m);

        // Press in halt is discarded and not replayed on entering single-step.
        bif.mode = 2'b00;
        episode(0, 6, 20, 0, ch_m);
        bif.mode = 2'b10;
        idle(15);
        chk("step_count_discard", bif.step_count, count_m);

        // LED paging on channel 2.
        bif.dbg_bus[47:32] = 16'hA55A;
        bif.ch_sel = 2'd2;
        ch_m = 2'd2;
        page_m = 0;
        tick();
        chk("led_ch2_p0", bif.led, 8'h5A);
        episode(1, 6, 20, 0, ch_m);
        chk("led_ch2_p1", bif.led, 8'hA5);
        episode(1, 6, 20, 0, ch_m);
        chk("page_wrap", bif.page, 1'b0);
        chk("led_ch2_wrap", bif.led, 8'h5A);

        // Select change on the very cycle the page pulse lands.
        episode(1, 6, 20, 0, ch_m);
        chk("page_before_sel", bif.page, 1'b1);
        episode(1, 6, 20, PRESS_LAT, 2'd3);
        chk("page_sel_prio", bif.page, 1'b0);
        chk("led_ch3", bif.led, led_ref(bif.dbg_bus, 3, 0));

        // Out-of-range select on a 3-channel instance falls back to channel 0.
        bif3.ch_sel = 2'd3;
        tick();
        tick();
        chk("led_oob", bif3.led, 8'hFF);
        bif3.ch_sel = 2'd2;
        tick();
        tick();
        chk("led_ch2_nch3", bif3.led, r[23:16]);

        for (int it = 0; it < 24; it++) begin
            act = $urandom_range(0, 3);
            h   = $urandom_range(1, 8);
            case (act)
                0: free_run($urandom_range(1, 30));
                1: begin
                    bif.mode = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b00;
                    episode(0, h, h + 14, 0, ch_m);
                end
                2: begin
                    chg = ($urandom_range(0, 2) == 0) ? $urandom_range(1, h + 14) : 0;
                    nch = 2'($urandom_range(0, 3));
                    episode(1, h, h + 14, chg, nch);
                end
                default: begin
                    nch = 2'($urandom_range(0, 3));
                    bif.dbg_bus = {$urandom(), $urandom()};
                    bif.ch_sel = nch;
                    if (nch != ch_m) page_m = 0;
                    ch_m = nch;
                    tick();
                    tick();
                    chk("led_rand", bif.led, led_ref(bif.dbg_bus, ch_m, page_m));
                    chk("page_rand", bif.page, page_m);
                end
            endcase
        end

        // Step count wraps through 2^CNT_W-1 to 0.
        bif.mode = 2'b10;
        for (int n = 0; n < CNT_MOD && count_m != 0; n++) episode(0, 5, 19, 0, ch_m);
        chk("step_count_wrap", bif.step_count, 4'd0);
        episode(0, 5, 19, 0, ch_m);
        if (page_m == 0) episode(1, 5, 19, 0, ch_m);

        // Asynchronous reset mid-divider and mid-debounce.
        bif.mode = 2'b01;
        tick();
        tick();
        bif.step_btn = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        chk("div_mid", dut.div_q, 3'd6);
        rst_n = 1'b0;
        #2;
        chk("arst_cpu_ce", bif.cpu_ce, 1'b0);
        chk("arst_led", bif.led, 8'h00);
        chk("arst_page", bif.page, 1'b0);
        chk("arst_step_count", bif.step_count, 4'h0);
        chk("arst_div", dut.div_q, 3'd0);
        bif.mode = 2'b10;
        tick();
        chk("arst_hold_cpu_ce", bif.cpu_ce, 1'b0);
        rst_n = 1'b1;
        count_m = 0;
        page_m = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("cpu_ce_after_rst", bif.cpu_ce, k == PRESS_LAT);
        end
        bif.step_btn = 1'b0;
        idle(12);
        chk("step_count_after_rst", bif.step_count, 4'd1);
        chk("led_after_rst", bif.led, led_ref(bif.dbg_bus, ch_m, 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
